// File: rtl/frame_write_sequencer.sv
// frame_write_sequencer: takes a header word that selects a frame, loads NumRows
// data words into FrameData, then pulses one FrameStrobe line to commit them.
module frame_write_sequencer #(
   parameter int unsigned FrameBitsPerRow = 32,
   parameter int unsigned MaxFramesPerCol = 20,
   parameter int unsigned NumRows         = 4
) (
   input  logic                               UserCLK,
   input  logic                               Reset,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic [FrameBitsPerRow-1:0]         s_data,
   input  logic                               err_clr,
   output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0]         FrameStrobe,
   output logic                               busy,
   output logic                               err,
   output logic [15:0]                        frame_count
);

   localparam int unsigned     RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
   localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] STROBE = 2'd2;
   localparam logic [1:0] HOLD   = 2'd3;

   logic [1:0]                 state;
   logic [1:0]                 state_next;
   logic [RowW-1:0]            row_cnt;
   logic [4:0]                 frame_idx;
   logic [FrameBitsPerRow-1:0] rows [NumRows];
   logic                       err_flag;
   logic [15:0]                frame_cnt;
   logic                       accept;
   logic                       hdr_ok;
   logic                       bad_hdr;

   assign accept  = s_valid & s_ready;
   // Header marker sits in the top nibble; the index must address an existing strobe line.
   assign hdr_ok  = (s_data[31:28] == 4'hF) && (32'(s_data[4:0]) < MaxFramesPerCol);
   assign bad_hdr = (state == IDLE) && accept && !hdr_ok;

   // Next-state decode.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept && hdr_ok) state_next = LOAD;
         LOAD:    if (accept && (row_cnt == LastRow)) state_next = STROBE;
         STROBE:  state_next = HOLD;
         default: state_next = IDLE;
      endcase
   end

   // State, frame index and row counter; the counter only moves on accepted LOAD words.
   always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         row_cnt   <= '0;
         frame_idx <= '0;
      end else begin
         state <= state_next;
         if ((state == IDLE) && accept && hdr_ok) begin
            frame_idx <= s_data[4:0];
            row_cnt   <= '0;
         end else if ((state == LOAD) && accept) begin
            row_cnt <= (row_cnt == LastRow) ? '0 : row_cnt + 1'b1;
         end
      end
   end

   // Row storage: written only by LOAD, otherwise retains the last frame's data.
   always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
         for (int unsigned k = 0; k < NumRows; k++) begin
            rows[k] <= '0;
         end
      end else if ((state == LOAD) && accept) begin
         rows[row_cnt] <= s_data;
      end
   end

   // Sticky error flag; a bad header in the same cycle as err_clr keeps it set.
   always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
         err_flag <= 1'b0;
      end else if (bad_hdr) begin
         err_flag <= 1'b1;
      end else if (err_clr) begin
         err_flag <= 1'b0;
      end
   end

   // Completed-write counter, bumped as STROBE hands over to HOLD; wraps naturally.
   always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
         frame_cnt <= '0;
      end else if (state == STROBE) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Strobe decodes straight from state so an async reset drops it immediately.
   always_comb begin
      FrameStrobe = '0;
      if (state == STROBE) begin
         for (int unsigned i = 0; i < MaxFramesPerCol; i++) begin
            FrameStrobe[i] = (frame_idx == 5'(i));
         end
      end
   end

   for (genvar k = 0; k < NumRows; k++) begin : g_rows
      assign FrameData[k*FrameBitsPerRow +: FrameBitsPerRow] = rows[k];
   end

   assign s_ready     = (state == IDLE) || (state == LOAD);
   assign busy        = (state != IDLE);
   assign err         = err_flag;
   assign frame_count = frame_cnt;

endmodule
